reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Round-robin arbiter that shares one 32-bit register-interface target port (the peripheral reg bus feeding the register demux) among NumReq reg_req_t requesters such as the AXI-to-reg bridge and debug/DMA reg masters. It grants one requester at a time, forwards its request unchanged, and routes the response back only to the granted requester. It optionally guards each transaction with a watchdog that completes a hung access with an error.

## Interface
- NumReq, 2: number of requesters; legal range 2..16.
- TimeoutCycles, 256: BUSY cycles before the watchdog fires; only used with the macro; must be ≥ 2.
- req_t, core_v_mcu_pkg::reg_req_t: request struct with addr, write, wdata, wstrb, valid.
- rsp_t, core_v_mcu_pkg::reg_rsp_t: response struct with rdata, error, ready.
- clk_i  in  1  clock; the block has one clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  NumReq×req_t  requester requests.
- rsp_o  out  NumReq×rsp_t  requester responses.
- req_o  out  req_t  request to the shared target.
- rsp_i  in  rsp_t  response from the shared target.
- gnt_idx_o  out  SelW = max(1,$clog2(NumReq))  index of the current/last grant.
- busy_o  out  1  high in BUSY.
- timeout_o  out  1  one-cycle pulse on watchdog completion; constant 0 without the macro.

## Operation
- FSM states: IDLE, BUSY.
- Reset: state = IDLE, rr_ptr = 0, gnt_idx = 0, watchdog counter = 0. All outputs are 0: every rsp_o is '0, req_o is '0, busy_o = 0, gnt_idx_o = 0, timeout_o = 0.
- IDLE:
  - req_o.valid = 0 and all rsp_o.ready = 0.
  - If any req_i[k].valid is set, grant the first valid index at or after rr_ptr, wrapping modulo NumReq.
  - Register gnt_idx and go to BUSY. No request is forwarded in the grant cycle.
- BUSY:
  - req_o = req_i[gnt_idx], combinationally.
  - rsp_o[gnt_idx] = rsp_i. Every other rsp_o is '0.
  - When rsp_i.ready = 1, the transaction completes: rr_ptr ← (gnt_idx+1) mod NumReq and the FSM goes to IDLE.
- Requesters must hold valid and payload until ready.
- If req_i[gnt_idx].valid drops in BUSY (protocol violation), forward valid = 0, give no response, go to IDLE, and advance rr_ptr as on completion.
- Non-granted requesters see ready = 0 and simply wait. No request is ever lost or duplicated.
- Fairness: a continuously requesting requester waits at most NumReq−1 transactions.

## Timing
- Grant latency is 1 cycle: valid is seen in IDLE in cycle t, and req_o.valid is asserted in cycle t+1.
- A zero-wait target completes in the same cycle as req_o.valid, giving 2 cycles per transaction. Back-to-back throughput is 1 transaction per 2 cycles.
- The response path rsp_i → rsp_o is combinational. The request path req_i → req_o is combinational after the grant.
- Simultaneous requests in the same IDLE cycle are resolved by rr_ptr only.
- Reset asserted mid-transaction:
  - Immediately forces IDLE and drops req_o.valid.
  - The granted requester receives no response.
  - The target must tolerate the abandoned access; reg targets are stateless per access.

## Configuration
- REG_BUS_ARBITER_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without rsp_i.ready.
  - When the counter equals TimeoutCycles−1 and ready is still low, the block drives rsp_o[gnt_idx] = {ready:1, error:1, rdata:32'h0}.
  - In that same cycle it forces req_o.valid = 0, pulses timeout_o, advances rr_ptr and goes to IDLE.
  - A ready arriving in that same cycle takes precedence: normal completion, no timeout.
- REG_BUS_ARBITER_TIMEOUT_EN undefined:
  - No counter is built.
  - timeout_o is tied to 0.
  - BUSY waits indefinitely.

## Structure
- core_v_mcu_pkg holds reg_req_t/reg_rsp_t (already present) and adds RegArbNumReq and RegArbTimeoutCycles constants.
- Sub-module reg_bus_arb_watchdog (counter plus compare, with start/clear/ready inputs and an expire output) is instantiated only under the macro.
- The round-robin select stays inline as a priority search from rr_ptr.

## Test plan
- Single requester: req_i[1] writes addr 0x0000_0010, wdata 0xA5A5_A5A5; target ready on the first forwarded cycle → req_o.valid asserted 1 cycle after req_i[1].valid; rsp_o[1].ready pulses once; gnt_idx_o = 1; 2 cycles total.
- Contention, NumReq = 4: all four valid continuously after reset → grants in order 0, 1, 2, 3, 0; each requester gets ready exactly once per 4 transactions.
- Wait states: target holds ready low for 5 cycles → req_o held stable, busy_o high for 6 cycles, no other rsp_o.ready asserted.
- Timeout, macro on, TimeoutCycles = 8: target never ready → on the 8th BUSY cycle rsp_o[gnt].error = 1, ready = 1, timeout_o pulses once, next requester is granted. Macro off: busy_o stays high.
- Reset in BUSY: rst_i pulsed during a stalled read → next cycle req_o = '0, busy_o = 0, gnt_idx_o = 0; the following request is granted from index 0.
- Withdrawn request: granted requester drops valid after 2 BUSY cycles → FSM returns to IDLE, no response is issued, rr_ptr advances.

Source files
------------

// File: rtl/core_v_mcu_pkg.sv
// Shared register-bus request/response types plus the reg bus arbiter
// defaults and FSM state encoding.
package core_v_mcu_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam int unsigned RegArbNumReq        = 2;
  localparam int unsigned RegArbTimeoutCycles = 256;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/reg_bus_arb_watchdog.sv
// Transaction watchdog for reg_bus_arbiter: counts stalled BUSY cycles and
// flags expiry on the last allowed cycle if the target is still not ready.
module reg_bus_arb_watchdog #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);

  logic [CntW-1:0] cnt_q;

  assign expire_o = start_i && !ready_i && (cnt_q == CntW'(TimeoutCycles - 1));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (start_i && !ready_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one reg bus target among NumReq requesters.
// Define REG_BUS_ARBITER_TIMEOUT_EN to build the per-transaction watchdog.
module reg_bus_arbiter
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NumReq        = RegArbNumReq,
  parameter int unsigned TimeoutCycles = RegArbTimeoutCycles,
  parameter type         req_t         = reg_req_t,
  parameter type         rsp_t         = reg_rsp_t,
  localparam int unsigned SelW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  req_t [NumReq-1:0]     req_i,
  output rsp_t [NumReq-1:0]     rsp_o,
  output req_t                  req_o,
  input  rsp_t                  rsp_i,
  output logic [SelW-1:0]       gnt_idx_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  if (NumReq < 2 || NumReq > 16) begin : g_bad_num_req
    $error("reg_bus_arbiter: NumReq must be in 2..16");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("reg_bus_arbiter: TimeoutCycles must be >= 2");
  end

  arb_state_e      state_q, state_d;
  logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SelW-1:0] gnt_q, gnt_d;
  logic [SelW-1:0] arb_idx, next_ptr;
  logic            arb_found;
  int unsigned     cand;
  logic            wd_expire;

`ifdef REG_BUS_ARBITER_TIMEOUT_EN
  reg_bus_arb_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (state_q == ArbBusy),
    .clear_i  (state_q == ArbIdle),
    .ready_i  (rsp_i.ready),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // First valid requester at or after rr_ptr, wrapping modulo NumReq.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!arb_found && req_i[SelW'(cand)].valid) begin
        arb_found = 1'b1;
        arb_idx   = SelW'(cand);
      end
    end
  end

  assign next_ptr = (gnt_q == SelW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    req_o     = '0;
    rsp_o     = '0;
    timeout_o = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (arb_found) begin
          gnt_d   = arb_idx;
          state_d = ArbBusy;
        end
      end
      ArbBusy: begin
        req_o = req_i[gnt_q];
        if (!req_i[gnt_q].valid) begin
          // Withdrawn request: nothing forwarded back, slot counts as used.
          state_d  = ArbIdle;
          rr_ptr_d = next_ptr;
        end else begin
          rsp_o[gnt_q] = rsp_i;
          if (rsp_i.ready) begin
            state_d  = ArbIdle;
            rr_ptr_d = next_ptr;
          end else if (wd_expire) begin
            rsp_o[gnt_q]       = '0;
            rsp_o[gnt_q].ready = 1'b1;
            rsp_o[gnt_q].error = 1'b1;
            req_o.valid        = 1'b0;
            timeout_o          = 1'b1;
            state_d            = ArbIdle;
            rr_ptr_d           = next_ptr;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ArbIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

  assign gnt_idx_o = gnt_q;
  assign busy_o    = (state_q == ArbBusy);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with four requesters; covers both
// builds of the REG_BUS_ARBITER_TIMEOUT_EN watchdog.
module tb_reg_bus_arbiter;
  import core_v_mcu_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  reg_req_t [3:0] req_i;
  reg_rsp_t [3:0] rsp_o;
  reg_req_t       req_o;
  reg_rsp_t       rsp_i;
  logic [1:0]     gnt_idx_o;
  logic           busy_o;
  logic           timeout_o;

  int n_cmp = 0;
  int n_mismatch = 0;
  int tally [4];
  int exp_gnt [5] = '{0, 1, 2, 3, 0};

  reg_bus_arbiter #(
    .NumReq       (4),
    .TimeoutCycles(8)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .rsp_o    (rsp_o),
    .req_o    (req_o),
    .rsp_i    (rsp_i),
    .gnt_idx_o(gnt_idx_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic reg_req_t mk(input logic [31:0] a, input logic w,
                                  input logic [31:0] d, input logic v);
    reg_req_t r;
    r.addr  = a;
    r.write = w;
    r.wdata = d;
    r.wstrb = 4'hF;
    r.valid = v;
    return r;
  endfunction

  initial begin
    rst_i = 1'b1;
    req_i = '0;
    rsp_i = '0;
    step();
    step();
    check("rst_req_o", req_o, 0);
    check("rst_rsp_o", rsp_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_gnt", gnt_idx_o, 0);
    check("rst_timeout", timeout_o, 0);

    // Single requester, zero-wait target.
    rst_i    = 1'b0;
    req_i[1] = mk(32'h0000_0010, 1'b1, 32'hA5A5_A5A5, 1'b1);
    rsp_i    = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    settle();
    check("single_idle_valid", req_o.valid, 0);
    check("single_idle_rdy", rsp_o[1].ready, 0);
    step();
    settle();
    check("single_busy", busy_o, 1);
    check("single_gnt", gnt_idx_o, 1);
    check("single_valid", req_o.valid, 1);
    check("single_addr", req_o.addr, 32'h10);
    check("single_wdata", req_o.wdata, 32'hA5A5_A5A5);
    check("single_rdy1", rsp_o[1].ready, 1);
    check("single_rdy0", rsp_o[0].ready, 0);
    step();
    req_i[1] = '0;
    settle();
    check("single_done_busy", busy_o, 0);
    check("single_done_rdy", rsp_o[1].ready, 0);

    // Contention from reset: all four continuously valid.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_i[k] = mk(32'h100 + 32'(k), 1'b0, 32'h0, 1'b1);
      tally[k] = 0;
    end
    settle();
    check("cont_idle", busy_o, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      settle();
      check("cont_busy", busy_o, 1);
      check("cont_gnt", gnt_idx_o, exp_gnt[i]);
      check("cont_addr", req_o.addr, 32'h100 + 32'(exp_gnt[i]));
      if (i < 4) begin
        for (int k = 0; k < 4; k++) tally[k] += int'(rsp_o[k].ready);
      end
      step();
      settle();
      check("cont_gap", busy_o, 0);
    end
    for (int k = 0; k < 4; k++) check("cont_tally", tally[k], 1);

    // Wait states: target stalls 5 cycles; requester 0 must keep waiting.
    req_i    = '0;
    req_i[2] = mk(32'h20, 1'b0, 32'h0, 1'b1);
    req_i[0] = mk(32'h30, 1'b0, 32'h0, 1'b1);
    rsp_i    = '0;
    for (int b = 1; b <= 6; b++) begin
      step();
      if (b == 6) rsp_i = '{rdata: 32'hDEAD_BEEF, error: 1'b0, ready: 1'b1};
      settle();
      check("ws_busy", busy_o, 1);
      check("ws_gnt", gnt_idx_o, 2);
      check("ws_addr", req_o.addr, 32'h20);
      check("ws_valid", req_o.valid, 1);
      check("ws_other_rdy", rsp_o[0].ready, 0);
      check("ws_rdy", rsp_o[2].ready, (b == 6) ? 1 : 0);
    end
    check("ws_rdata", rsp_o[2].rdata, 32'hDEAD_BEEF);
    step();
    req_i[2] = '0;
    req_i[1] = mk(32'h40, 1'b0, 32'h0, 1'b1);
    rsp_i    = '{rdata: 32'h1234_5678, error: 1'b0, ready: 1'b0};
    settle();
    check("ws_done", busy_o, 0);

`ifdef REG_BUS_ARBITER_TIMEOUT_EN
    for (int b = 1; b <= 8; b++) begin
      step();
      settle();
      check("to_busy", busy_o, 1);
      check("to_gnt", gnt_idx_o, 0);
      if (b < 8) begin
        check("to_quiet", timeout_o, 0);
        check("to_no_rdy", rsp_o[0].ready, 0);
      end else begin
        check("to_pulse", timeout_o, 1);
        check("to_rdy", rsp_o[0].ready, 1);
        check("to_err", rsp_o[0].error, 1);
        check("to_rdata", rsp_o[0].rdata, 0);
        check("to_valid", req_o.valid, 0);
        check("to_other_rdy", rsp_o[1].ready, 0);
      end
    end
    step();
    req_i[0] = '0;
    settle();
    check("to_idle", busy_o, 0);
    check("to_once", timeout_o, 0);
`else
    for (int b = 1; b <= 20; b++) begin
      step();
      settle();
      check("nto_busy", busy_o, 1);
      check("nto_gnt", gnt_idx_o, 0);
      check("nto_quiet", timeout_o, 0);
    end
    step();
    rsp_i.ready = 1'b1;
    settle();
    check("nto_rdy", rsp_o[0].ready, 1);
    step();
    req_i[0]    = '0;
    rsp_i.ready = 1'b0;
    settle();
    check("nto_idle", busy_o, 0);
`endif
    step();
    settle();
    check("next_busy", busy_o, 1);
    check("next_gnt", gnt_idx_o, 1);

    // Reset during a stalled read.
    step();
    rst_i = 1'b1;
    settle();
    check("rb_req_o", req_o, 0);
    check("rb_rsp_o", rsp_o, 0);
    check("rb_busy", busy_o, 0);
    check("rb_gnt", gnt_idx_o, 0);
    step();
    rst_i    = 1'b0;
    req_i[0] = mk(32'h50, 1'b1, 32'h0000_0055, 1'b1);
    settle();
    check("rb_idle", busy_o, 0);
    step();
    rsp_i.ready = 1'b1;
    settle();
    check("rb_gnt_after", gnt_idx_o, 0);
    check("rb_rdy", rsp_o[0].ready, 1);
    step();
    req_i[0] = '0;
    rsp_i    = '0;
    settle();
    check("rb_done", busy_o, 0);

    // Withdrawn request after two BUSY cycles.
    step();
    settle();
    check("wd_gnt", gnt_idx_o, 1);
    step();
    settle();
    check("wd_busy2", busy_o, 1);
    step();
    req_i[1].valid = 1'b0;
    rsp_i.ready    = 1'b1;
    settle();
    check("wd_valid", req_o.valid, 0);
    check("wd_no_rsp", rsp_o, 0);
    step();
    req_i[1].valid = 1'b1;
    req_i[2]       = mk(32'h60, 1'b0, 32'h0, 1'b1);
    rsp_i          = '0;
    settle();
    check("wd_idle", busy_o, 0);
    step();
    settle();
    check("wd_ptr_adv", gnt_idx_o, 2);

    req_i       = '0;
    rsp_i.ready = 1'b1;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mismatch);
    $finish;
  end

endmodule
